lift_car_controller: RTL

Per-car controller sitting at the far end of the dispatcher-to-car link. It accepts the 11-bit floor-request vector assigned to this car, merges it with in-car button presses, and moves the car floor by floor using SCAN ordering: it keeps its current direction while requests remain ahead, then reverses. It reports its current floor back to the dispatcher and pulses a per-floor served vector so that upstream request bits can be retired.

---
 rtl/lift_car_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lift_car_controller.sv
`default_nettype none
// ============================================================================
// Module   : lift_car_controller
// Brief    : Per-car SCAN controller; merges dispatcher and in-car requests,
//            moves floor by floor, reports floor and pulses served stops.
// Revision : 1.0 - initial release
// ============================================================================
module lift_car_controller #(
  parameter int NUM_FLOORS  = 11,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] FloortoLift,
  input  logic [10:0] CarReq,
  output logic [3:0]  liftstate,
  output logic        moving_up,
  output logic        moving_down,
  output logic        door_open,
  output logic [10:0] served
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOVE_LOAD  = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_CYCLES - 1);
  localparam logic [10:0]   FLOOR_MASK = 11'((1 << NUM_FLOORS) - 1);
  localparam logic          DIR_UP     = 1'b1;
  localparam logic          DIR_DOWN   = 1'b0;

  state_t        state_q, state_d, next_st;
  logic [3:0]    floor_q, floor_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic [10:0]   pending_q, pending_d;
  logic [10:0]   served_q, served_d;
  logic          moving_up_q, moving_up_d;
  logic          moving_down_q, moving_down_d;
  logic          door_open_q, door_open_d;
  logic [10:0]   req_m;
  logic          enter;

  function automatic logic [10:0] onehot(input logic [3:0] f);
    logic [10:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) begin
      if (4'(i) == f) v[i] = 1'b1;
    end
    return v;
  endfunction

  // SCAN decision: serve here, else keep heading while work lies ahead, else reverse.
  function automatic state_t decide(input logic [3:0] f, input logic [10:0] p,
                                    input logic d);
    logic here, above, below;
    state_t s;
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (4'(i) == f) here  = here  | p[i];
      if (4'(i) >  f) above = above | p[i];
      if (4'(i) <  f) below = below | p[i];
    end
    if (here)                     s = ST_DOOR_OPEN;
    else if (d == DIR_UP && above) s = ST_MOVE_UP;
    else if (d == DIR_UP && below) s = ST_MOVE_DOWN;
    else if (below)                s = ST_MOVE_DOWN;
    else if (above)                s = ST_MOVE_UP;
    else                           s = ST_IDLE;
    return s;
  endfunction

  always_comb begin
    req_m     = (FloortoLift | CarReq) & FLOOR_MASK;
    state_d   = state_q;
    floor_d   = floor_q;
    timer_d   = timer_q;
    dir_d     = dir_q;
    served_d  = '0;
    next_st   = state_q;
    enter     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        next_st = decide(floor_q, pending_q, dir_q);
        enter   = 1'b1;
      end
      ST_MOVE_UP: begin
        if (timer_q == '0) begin
          floor_d = floor_q + 4'd1;
          next_st = decide(floor_d, pending_q, dir_q);
          enter   = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_MOVE_DOWN: begin
        if (timer_q == '0) begin
          floor_d = floor_q - 4'd1;
          next_st = decide(floor_d, pending_q, dir_q);
          enter   = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DOOR_OPEN: begin
        // A fresh call for this floor holds the door and is retired immediately.
        if ((req_m & onehot(floor_q)) != '0) begin
          served_d = onehot(floor_q);
          timer_d  = DOOR_LOAD;
        end else if (timer_q == '0) begin
          next_st = decide(floor_q, pending_q, dir_q);
          enter   = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        next_st = ST_IDLE;
        enter   = 1'b1;
      end
    endcase

    if (enter) begin
      state_d = next_st;
      case (next_st)
        ST_MOVE_UP: begin
          timer_d = MOVE_LOAD;
          dir_d   = DIR_UP;
        end
        ST_MOVE_DOWN: begin
          timer_d = MOVE_LOAD;
          dir_d   = DIR_DOWN;
        end
        ST_DOOR_OPEN: begin
          timer_d  = DOOR_LOAD;
          served_d = onehot(floor_d);
        end
        default: timer_d = '0;
      endcase
    end

    pending_d     = (pending_q | req_m) & ~served_d;
    moving_up_d   = (state_d == ST_MOVE_UP);
    moving_down_d = (state_d == ST_MOVE_DOWN);
    door_open_d   = (state_d == ST_DOOR_OPEN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      floor_q       <= '0;
      timer_q       <= '0;
      dir_q         <= DIR_UP;
      pending_q     <= '0;
      served_q      <= '0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      timer_q       <= timer_d;
      dir_q         <= dir_d;
      pending_q     <= pending_d;
      served_q      <= served_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      door_open_q   <= door_open_d;
    end
  end

  assign liftstate   = floor_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;
  assign door_open   = door_open_q;
  assign served      = served_q;

endmodule
`default_nettype wire
